// File: rtl/pll_pkg.sv
// pll_pkg
//   Shared types and default widths for the PLL control sequencer.
//   Contents:
//     PLL_N_SIZE, PLL_COUNT_SIZE, PLL_K_SIZE : default widths of the divide
//                                              ratio, the DCO count and the gains
//     pll_ctrl_state_t                       : sequencer state encoding
package pll_pkg;

    localparam int PLL_N_SIZE     = 8;
    localparam int PLL_COUNT_SIZE = 8;
    localparam int PLL_K_SIZE     = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACQUIRE,
        TRACK,
        FAULT
    } pll_ctrl_state_t;

endpackage

// File: rtl/pll_lock_det.sv
// pll_lock_det
//   Consecutive-window counter. It counts back-to-back cycles with hit high.
//   A cycle with hit low, or with clear high, restarts the count from zero.
//   done is high on the cycle in which the WINDOW-th consecutive hit is
//   sampled, so the caller can act on the same clock edge.
//   Ports:
//     clk_ref : clock
//     rst     : synchronous active-high reset
//     hit     : this cycle counts towards the window
//     clear   : force the count to zero (takes priority over hit)
//     done    : WINDOW consecutive hits reached, including this cycle
module pll_lock_det #(
    parameter int WINDOW = 64
) (
    input  logic clk_ref,
    input  logic rst,
    input  logic hit,
    input  logic clear,
    output logic done
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
    localparam logic [CW-1:0] FULL = CW'(WINDOW);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = '0;
        if (!clear && hit) begin
            // Saturate so a long in-tolerance run cannot wrap back to zero.
            count_next = (count_reg >= LAST) ? FULL : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign done = !clear && hit && (count_reg >= LAST);

endmodule

// File: rtl/pll_ctrl.sv
// pll_ctrl
//   Configuration and lock-management sequencer for the PLL control inputs.
//   IDLE -> SETTLE (dco_count ignored) -> ACQUIRE (acquisition gains) ->
//   TRACK (tracking gains, locked) and back to ACQUIRE on loss of lock.
//   Compile-time option: define PLL_CTRL_TIMEOUT_EN to add an acquisition
//   watchdog that moves to FAULT after TIMEOUT_CYCLES in ACQUIRE without
//   lock. Without it, fault stays 0 and FAULT is never entered.
//   Ports:
//     clk_ref, rst               : clock, synchronous active-high reset
//     cfg_valid, cfg_ready, n_req: target ratio handshake (accepted in IDLE)
//     stop                       : return to IDLE, highest priority
//     kp/ki_acq, kp/ki_trk       : acquisition and tracking gains
//     dco_count                  : DCO cycles in the last reference period
//     n, kp, ki, enable          : registered controls to the PLL
//     locked, lost_lock, fault   : registered status
module pll_ctrl
    import pll_pkg::*;
#(
    parameter int N_SIZE         = PLL_N_SIZE,
    parameter int COUNT_SIZE     = PLL_COUNT_SIZE,
    parameter int K_SIZE         = PLL_K_SIZE,
    parameter int LOCK_TOL       = 1,
    parameter int LOCK_CYCLES    = 64,
    parameter int UNLOCK_TOL     = 4,
    parameter int UNLOCK_CYCLES  = 4,
    parameter int SETTLE_CYCLES  = 8
`ifdef PLL_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                  clk_ref,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [N_SIZE-1:0]     n_req,
    input  logic                  stop,
    input  logic [K_SIZE-1:0]     kp_acq,
    input  logic [K_SIZE-1:0]     ki_acq,
    input  logic [K_SIZE-1:0]     kp_trk,
    input  logic [K_SIZE-1:0]     ki_trk,
    input  logic [COUNT_SIZE-1:0] dco_count,
    output logic [N_SIZE-1:0]     n,
    output logic [K_SIZE-1:0]     kp,
    output logic [K_SIZE-1:0]     ki,
    output logic                  enable,
    output logic                  locked,
    output logic                  lost_lock,
    output logic                  fault
);

    // One extra bit so |dco_count - n| never wraps.
    localparam int DW = COUNT_SIZE + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    pll_ctrl_state_t   state_reg;
    logic [SW-1:0]     settle_reg;
    logic [N_SIZE-1:0] n_reg;
    logic [K_SIZE-1:0] kp_reg;
    logic [K_SIZE-1:0] ki_reg;
    logic              enable_reg;
    logic              locked_reg;
    logic              lost_lock_reg;
    logic              fault_reg;
    logic              cfg_ready_reg;

    logic [DW-1:0] dco_ext;
    logic [DW-1:0] n_ext;
    logic [DW-1:0] diff;
    logic          in_tol;
    logic          out_tol;
    logic          timeout_hit;

    assign dco_ext = {1'b0, dco_count};
    assign n_ext   = DW'(n_reg);
    assign diff    = (dco_ext >= n_ext) ? (dco_ext - n_ext) : (n_ext - dco_ext);
    assign in_tol  = (diff <= DW'(LOCK_TOL));
    assign out_tol = (diff >  DW'(UNLOCK_TOL));

    // Window detectors: index 0 declares lock in ACQUIRE, index 1 declares
    // loss of lock in TRACK. Each is held cleared outside its own state, so
    // it always starts from zero on state entry.
    logic [1:0] det_hit;
    logic [1:0] det_clear;
    logic [1:0] det_done;

    assign det_hit[0]   = (state_reg == ACQUIRE) && in_tol;
    assign det_clear[0] = (state_reg != ACQUIRE) || stop;
    assign det_hit[1]   = (state_reg == TRACK) && out_tol;
    assign det_clear[1] = (state_reg != TRACK) || stop;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_det
            pll_lock_det #(
                .WINDOW((gi == 0) ? LOCK_CYCLES : UNLOCK_CYCLES)
            ) u_det (
                .clk_ref (clk_ref),
                .rst     (rst),
                .hit     (det_hit[gi]),
                .clear   (det_clear[gi]),
                .done    (det_done[gi])
            );
        end
    endgenerate

`ifdef PLL_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd_reg;

    // Counts every ACQUIRE cycle regardless of tolerance; zero outside
    // ACQUIRE so each entry starts a fresh budget.
    always_ff @(posedge clk_ref) begin
        if (rst || stop || (state_reg != ACQUIRE)) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == ACQUIRE) && (wd_reg == WD_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_reg     <= IDLE;
            settle_reg    <= '0;
            n_reg         <= '0;
            kp_reg        <= '0;
            ki_reg        <= '0;
            enable_reg    <= 1'b0;
            locked_reg    <= 1'b0;
            lost_lock_reg <= 1'b0;
            fault_reg     <= 1'b0;
            cfg_ready_reg <= 1'b1;
        end else begin
            lost_lock_reg <= 1'b0;
            if (stop) begin
                // n/kp/ki deliberately hold their last values.
                state_reg     <= IDLE;
                settle_reg    <= '0;
                enable_reg    <= 1'b0;
                locked_reg    <= 1'b0;
                fault_reg     <= 1'b0;
                cfg_ready_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (cfg_valid && cfg_ready_reg && (n_req != '0)) begin
                            state_reg     <= SETTLE;
                            settle_reg    <= '0;
                            n_reg         <= n_req;
                            kp_reg        <= kp_acq;
                            ki_reg        <= ki_acq;
                            enable_reg    <= 1'b1;
                            cfg_ready_reg <= 1'b0;
                        end
                    end
                    SETTLE: begin
                        kp_reg <= kp_acq;
                        ki_reg <= ki_acq;
                        if (settle_reg == SETTLE_LAST) begin
                            state_reg <= ACQUIRE;
                        end else begin
                            settle_reg <= settle_reg + 1'b1;
                        end
                    end
                    ACQUIRE: begin
                        // Lock wins over a watchdog expiry on the same edge.
                        if (det_done[0]) begin
                            state_reg  <= TRACK;
                            locked_reg <= 1'b1;
                            kp_reg     <= kp_trk;
                            ki_reg     <= ki_trk;
                        end else if (timeout_hit) begin
                            state_reg  <= FAULT;
                            enable_reg <= 1'b0;
                            fault_reg  <= 1'b1;
                        end else begin
                            kp_reg <= kp_acq;
                            ki_reg <= ki_acq;
                        end
                    end
                    TRACK: begin
                        if (det_done[1]) begin
                            state_reg     <= ACQUIRE;
                            locked_reg    <= 1'b0;
                            lost_lock_reg <= 1'b1;
                            kp_reg        <= kp_acq;
                            ki_reg        <= ki_acq;
                        end else begin
                            kp_reg <= kp_trk;
                            ki_reg <= ki_trk;
                        end
                    end
                    FAULT: begin
                        // Held until stop or rst.
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_ready = cfg_ready_reg;
    assign n         = n_reg;
    assign kp        = kp_reg;
    assign ki        = ki_reg;
    assign enable    = enable_reg;
    assign locked    = locked_reg;
    assign lost_lock = lost_lock_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl
//   Directed bench for pll_ctrl. A cycle-level behavioural model written
//   from the sequencing rules (run lengths, ages, absolute error) predicts
//   every output; a negedge process compares DUT against it each cycle.
//   Directed steps add hand-computed literal expectations that pin the
//   model. Build with PLL_CTRL_TIMEOUT_EN defined to exercise the watchdog.
module tb_pll_ctrl;

    localparam int SETTLE_CYCLES  = 8;
    localparam int LOCK_CYCLES    = 64;
    localparam int UNLOCK_CYCLES  = 4;
    localparam int LOCK_TOL       = 1;
    localparam int UNLOCK_TOL     = 4;
    localparam int TIMEOUT_CYCLES = 4096;
`ifdef PLL_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  n_req;
    logic        stop;
    logic [15:0] kp_acq;
    logic [15:0] ki_acq;
    logic [15:0] kp_trk;
    logic [15:0] ki_trk;
    logic [7:0]  dco_count;
    logic [7:0]  n;
    logic [15:0] kp;
    logic [15:0] ki;
    logic        enable;
    logic        locked;
    logic        lost_lock;
    logic        fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_ctrl dut (
        .clk_ref   (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .n_req     (n_req),
        .stop      (stop),
        .kp_acq    (kp_acq),
        .ki_acq    (ki_acq),
        .kp_trk    (kp_trk),
        .ki_trk    (ki_trk),
        .dco_count (dco_count),
        .n         (n),
        .kp        (kp),
        .ki        (ki),
        .enable    (enable),
        .locked    (locked),
        .lost_lock (lost_lock),
        .fault     (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_SETTLE = 1, M_ACQ = 2, M_TRK = 3, M_FAULT = 4;
    int m_mode = M_IDLE;
    int m_n = 0, m_kp = 0, m_ki = 0;
    int m_en = 0, m_locked = 0, m_lost = 0, m_fault = 0, m_ready = 1;
    int settle_seen = 0, good_run = 0, bad_run = 0, acq_age = 0;
    int err;
    bit model_live = 1'b0;

    always @(posedge clk) begin
        m_lost = 0;
        err = int'(dco_count) - m_n;
        if (err < 0) err = -err;
        if (rst) begin
            m_mode = M_IDLE; m_n = 0; m_kp = 0; m_ki = 0;
            m_en = 0; m_locked = 0; m_fault = 0; m_ready = 1;
        end else if (stop) begin
            m_mode = M_IDLE; m_en = 0; m_locked = 0; m_fault = 0; m_ready = 1;
        end else begin
            case (m_mode)
                M_IDLE: if (cfg_valid && n_req != 0) begin
                    m_n = n_req; m_kp = kp_acq; m_ki = ki_acq;
                    m_en = 1; m_ready = 0; settle_seen = 0; m_mode = M_SETTLE;
                    $display("cfg txn accepted: n=%0d", n_req);
                end
                M_SETTLE: begin
                    m_kp = kp_acq; m_ki = ki_acq;
                    settle_seen++;
                    if (settle_seen == SETTLE_CYCLES) begin
                        m_mode = M_ACQ; good_run = 0; acq_age = 0;
                    end
                end
                M_ACQ: begin
                    good_run = (err <= LOCK_TOL) ? good_run + 1 : 0;
                    acq_age++;
                    if (good_run >= LOCK_CYCLES) begin
                        m_mode = M_TRK; m_locked = 1; bad_run = 0;
                        m_kp = kp_trk; m_ki = ki_trk;
                    end else if (TIMEOUT_ON && acq_age >= TIMEOUT_CYCLES) begin
                        m_mode = M_FAULT; m_en = 0; m_fault = 1;
                    end else begin
                        m_kp = kp_acq; m_ki = ki_acq;
                    end
                end
                M_TRK: begin
                    bad_run = (err > UNLOCK_TOL) ? bad_run + 1 : 0;
                    if (bad_run >= UNLOCK_CYCLES) begin
                        m_mode = M_ACQ; m_locked = 0; m_lost = 1;
                        good_run = 0; acq_age = 0;
                        m_kp = kp_acq; m_ki = ki_acq;
                    end else begin
                        m_kp = kp_trk; m_ki = ki_trk;
                    end
                end
                default: ;
            endcase
        end
        model_live = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            check("cyc_cfg_ready", 32'(cfg_ready), 32'(m_ready));
            check("cyc_n",         32'(n),         32'(m_n));
            check("cyc_kp",        32'(kp),        32'(m_kp));
            check("cyc_ki",        32'(ki),        32'(m_ki));
            check("cyc_enable",    32'(enable),    32'(m_en));
            check("cyc_locked",    32'(locked),    32'(m_locked));
            check("cyc_lost_lock", 32'(lost_lock), 32'(m_lost));
            check("cyc_fault",     32'(fault),     32'(m_fault));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic handshake(input logic [7:0] ratio);
        cfg_valid = 1'b1;
        n_req     = ratio;
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_locked(input int limit, output int cycles);
        cycles = 0;
        while (!locked && cycles < limit) begin
            cyc(1);
            cycles++;
        end
    endtask

    task automatic wait_fault(input int limit, output int cycles);
        cycles = 0;
        while (!fault && cycles < limit) begin
            cyc(1);
            cycles++;
        end
    endtask

    int lat;
    int pulses;

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; n_req = 8'd0; stop = 1'b0;
        kp_acq = 16'h1111; ki_acq = 16'h2222;
        kp_trk = 16'h0333; ki_trk = 16'h0044;
        dco_count = 8'd0;
        cyc(2);
        rst = 1'b0;
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset_enable",    32'(enable),    32'd0);
        check("reset_n",         32'(n),         32'd0);

        // Handshake: visible on the next edge; settle 8 + lock 64 = 72.
        dco_count = 8'd73;
        handshake(8'd72);
        check("hs_n",         32'(n),         32'd72);
        check("hs_kp",        32'(kp),        32'h1111);
        check("hs_enable",    32'(enable),    32'd1);
        check("hs_cfg_ready", 32'(cfg_ready), 32'd0);
        wait_locked(200, lat);
        check("lock_latency", 32'(lat), 32'd72);
        check("trk_kp", 32'(kp), 32'h0333);
        check("trk_ki", 32'(ki), 32'h0044);

        // Hysteresis band (diff 4) holds lock; diff 5 for 4 cycles drops it.
        dco_count = 8'd76;
        cyc(100);
        check("hyst_locked", 32'(locked), 32'd1);
        dco_count = 8'd77;
        pulses = 0;
        cyc(3);
        if (lost_lock) pulses++;
        check("pre_unlock_locked", 32'(locked), 32'd1);
        cyc(1);
        if (lost_lock) pulses++;
        check("unlock_locked", 32'(locked), 32'd0);
        check("unlock_kp",     32'(kp),     32'h1111);
        cyc(1);
        if (lost_lock) pulses++;
        check("lost_lock_pulses", 32'(pulses), 32'd1);

        // Gain change while acquiring shows on the next edge.
        kp_acq = 16'h1234;
        cyc(1);
        check("acq_gain_follow", 32'(kp), 32'h1234);

        // 63 good, 1 glitch, then a full 64-cycle run is needed.
        dco_count = 8'd71;
        cyc(63);
        dco_count = 8'd80;
        cyc(1);
        check("glitch_not_locked", 32'(locked), 32'd0);
        dco_count = 8'd73;
        wait_locked(200, lat);
        check("glitch_lock_latency", 32'(lat), 32'd64);

        // stop in TRACK: shut down, gains and ratio hold.
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("stop_enable", 32'(enable),    32'd0);
        check("stop_locked", 32'(locked),    32'd0);
        check("stop_ready",  32'(cfg_ready), 32'd1);
        check("stop_n_hold", 32'(n),         32'd72);
        check("stop_kp_hold",32'(kp),        32'h0333);

        // stop beats cfg_valid; n_req of zero is ignored.
        stop = 1'b1;
        handshake(8'd50);
        stop = 1'b0;
        check("stop_cfg_n",      32'(n),      32'd72);
        check("stop_cfg_enable", 32'(enable), 32'd0);
        handshake(8'd0);
        check("zero_req_enable", 32'(enable),    32'd0);
        check("zero_req_ready",  32'(cfg_ready), 32'd1);

        // diff 2 never locks; cfg_valid outside IDLE is ignored.
        dco_count = 8'd74;
        handshake(8'd72);
        cyc(20);
        handshake(8'd9);
        check("busy_cfg_n", 32'(n), 32'd72);
        cyc(300);
        check("off_by_two_unlocked", 32'(locked), 32'd0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;

        // Acquisition watchdog.
        dco_count = 8'd0;
        handshake(8'd72);
`ifdef PLL_CTRL_TIMEOUT_EN
        wait_fault(5000, lat);
        check("timeout_latency", 32'(lat),    32'd4104);
        check("timeout_enable",  32'(enable), 32'd0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("stop_clears_fault", 32'(fault), 32'd0);
`else
        cyc(10000);
        check("no_timeout_fault",  32'(fault),  32'd0);
        check("no_timeout_enable", 32'(enable), 32'd1);
`endif

        // Reset mid-operation.
        dco_count = 8'd73;
        handshake(8'd40);
        cyc(20);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("midrst_n",      32'(n),         32'd0);
        check("midrst_kp",     32'(kp),        32'd0);
        check("midrst_enable", 32'(enable),    32'd0);
        check("midrst_ready",  32'(cfg_ready), 32'd1);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish (t=%0t)", $time);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/pll_ctrl.md
Name: pll_ctrl

Overview:
Configuration and lock-management sequencer that drives the PLL's control inputs: divide ratio n, loop gains kp/ki, and enable.
- Accepts a target ratio via a valid/ready handshake and brings the loop up with high acquisition gains.
- Monitors the per-reference-period DCO cycle count and declares lock.
- Switches to low tracking gains on lock; falls back to acquisition gains on loss of lock.
- Sits beside the PLL top in the clk_ref domain, as the initiator of its control interface.

Parameters:
- N_SIZE, 8, width of divide ratio n.
- COUNT_SIZE, 8, width of dco_count; must satisfy N_SIZE <= COUNT_SIZE.
- K_SIZE, 16, width of kp/ki.
- LOCK_TOL, 1, max |dco_count - n| counted as in-tolerance.
- LOCK_CYCLES, 64, consecutive in-tolerance cycles required to declare lock.
- UNLOCK_TOL, 4, |dco_count - n| above this counts as out-of-tolerance while tracking.
- UNLOCK_CYCLES, 4, consecutive out-of-tolerance cycles required to declare loss of lock.
- SETTLE_CYCLES, 8, cycles after enable during which dco_count is ignored.
- TIMEOUT_CYCLES, 4096, acquisition watchdog limit (optional feature only).

Ports:
- clk_ref, in, 1, reference clock; the only clock.
- rst, in, 1, synchronous active-high reset.
- cfg_valid, in, 1, new target ratio offered.
- cfg_ready, out, 1, controller can accept a config.
- n_req, in, N_SIZE, requested divide ratio.
- stop, in, 1, shut the PLL down and return to IDLE.
- kp_acq, in, K_SIZE, acquisition proportional gain.
- ki_acq, in, K_SIZE, acquisition integral gain.
- kp_trk, in, K_SIZE, tracking proportional gain.
- ki_trk, in, K_SIZE, tracking integral gain.
- dco_count, in, COUNT_SIZE, DCO cycles in the last reference period; sampled every cycle.
- n, out, N_SIZE, divide ratio to the PLL.
- kp, out, K_SIZE, proportional gain to the PLL.
- ki, out, K_SIZE, integral gain to the PLL.
- enable, out, 1, PLL enable.
- locked, out, 1, lock status.
- lost_lock, out, 1, one-cycle pulse on loss of lock.
- fault, out, 1, acquisition timeout flag.

Behaviour:
- Clocking and reset: one clock, clk_ref. Reset is synchronous, active-high, and named rst.
- Reset values: state IDLE; n=0, kp=0, ki=0, enable=0, locked=0, lost_lock=0, fault=0, cfg_ready=1.
- Registered outputs: all outputs are registered and change on the clk_ref edge after the decision is made.
- States:
  - IDLE: enable=0, cfg_ready=1.
  - SETTLE: enable=1, acquisition gains.
  - ACQUIRE: enable=1, acquisition gains.
  - TRACK: enable=1, tracking gains, locked=1.
  - FAULT: enable=0, fault=1.
- cfg_ready is high only in IDLE. cfg_valid in any other state is ignored.
- IDLE, handshake fires (cfg_valid & cfg_ready, n_req != 0, stop=0):
  - latch n <= n_req, kp/ki <= acquisition gains, enable <= 1;
  - go to SETTLE with the settle counter cleared.
- IDLE, handshake with n_req == 0: ignored; stay in IDLE, no flag.
- SETTLE:
  - counts SETTLE_CYCLES cycles, dco_count ignored;
  - on the last cycle go to ACQUIRE with the lock counter at 0.
- Error arithmetic: diff = |dco_count - zero-extended n|, computed unsigned in COUNT_SIZE+1 bits with no wrap.
- ACQUIRE:
  - diff <= LOCK_TOL increments the lock counter; otherwise clear it to 0;
  - the counter saturates at LOCK_CYCLES;
  - on the cycle the counter reaches LOCK_CYCLES: next edge goes to TRACK, locked <= 1, kp/ki <= tracking gains (same edge).
- TRACK:
  - diff > UNLOCK_TOL increments the unlock counter; otherwise clear it;
  - on reaching UNLOCK_CYCLES: go to ACQUIRE, locked <= 0, kp/ki <= acquisition gains, lost_lock=1 for exactly one cycle, both counters cleared;
  - diffs between LOCK_TOL and UNLOCK_TOL form the hysteresis band: no effect in TRACK.
- Gain inputs: sampled when applied. A change to *_acq/*_trk while in the corresponding state is reflected in kp/ki on the next edge.
- stop: highest priority in every state.
  - Next edge: IDLE, enable=0, locked=0, fault=0, all counters cleared.
  - n/kp/ki hold their last values.
  - stop with cfg_valid in IDLE: the config is not accepted.
- Reset mid-operation: returns all state and outputs to reset values on the next edge, regardless of state.

Optional Feature:
- Macro: PLL_CTRL_TIMEOUT_EN.
- Defined:
  - a watchdog counts cycles since ACQUIRE entry; it is not reset by in-tolerance cycles, and is cleared on ACQUIRE entry;
  - reaching TIMEOUT_CYCLES without lock goes to FAULT: enable <= 0, fault <= 1;
  - FAULT is held until stop or rst.
- Not defined:
  - no watchdog logic; ACQUIRE lasts indefinitely;
  - fault is tied to 0 and FAULT is unreachable.

Decomposition:
- Package pll_pkg:
  - enum pll_ctrl_state_t {IDLE, SETTLE, ACQUIRE, TRACK, FAULT};
  - localparam defaults for K_SIZE, N_SIZE, COUNT_SIZE.
- Sub-module pll_lock_det:
  - consecutive-window counter with inputs hit and clear, parameter WINDOW;
  - output done;
  - instantiated twice, once for lock and once for unlock.

Test Plan:
- Reset/handshake: hold rst 2 cycles, then cfg_valid with n_req=72 -> cfg_ready drops, n=72, kp=kp_acq, enable=1 on the next edge; SETTLE lasts 8 cycles.
- Lock: dco_count=73 held constant -> locked=1 and kp/ki=trk exactly 64 cycles after ACQUIRE entry; dco_count=74 -> never locks.
- Hysteresis/unlock: in TRACK, dco_count=76 for 100 cycles -> locked stays 1. Then dco_count=77 for 4 cycles -> lost_lock pulses once, state ACQUIRE, acquisition gains.
- Lock reset by glitch: 63 in-tolerance cycles, 1 cycle at 80, then 64 in-tolerance -> lock asserted only after the second run.
- stop priority: stop during TRACK -> enable=0, locked=0 next edge. stop+cfg_valid in IDLE -> not accepted. n_req=0 -> ignored.
- Timeout (macro on): dco_count=0 after settle -> fault=1, enable=0 at 4096 cycles; stop clears fault. Macro off: no fault after 10000 cycles.
